ddr3_page_scheduler: RTL
========================

Name: ddr3_page_scheduler

Overview:
Sequences page-sized bursts between the pipe FIFO (write side), DDR3 and the decoder FIFO (read side). It arbitrates the controller's level enables, cmd_pagewrite and cmd_pageread, into MIG-style application commands, and keeps separate write and read page pointers over a circular DDR3 region. It sits between the command controller and the MIG user interface and counts stored pages, so a read never overtakes a write.

Parameters:
ADDR_W, 28, app_addr width
BURST_LEN, 64, beats per page (must be ≤127)
ADDR_STEP, 8, app_addr increment per beat
NUM_PAGES, 1024, pages in the ring; ring span = NUM_PAGES*BURST_LEN*ADDR_STEP
PCNT_W, 11, width of page counter (≥ clog2(NUM_PAGES+1))

Ports:
sdramclk  in  1  clock
sdram_rst_n  in  1  asynchronous reset, active-low
init_calib_complete  in  1  MIG calibration done
cmd_pagewrite  in  1  write enable level from controller
cmd_pageread  in  1  read enable level from controller
wr_fifo_count  in  7  words available in pipe FIFO
rd_fifo_space  in  7  free words in decoder FIFO
app_rdy  in  1  MIG command accept
app_wdf_rdy  in  1  MIG write-data accept
app_rd_data_valid  in  1  MIG read beat returned
app_en  out  1  command valid
app_cmd  out  3  000 write, 001 read
app_addr  out  ADDR_W  beat address
app_wdf_wren  out  1  write-data valid
app_wdf_end  out  1  last word of beat (single-word beats: equals app_wdf_wren)
wr_fifo_rden  out  1  pop pipe FIFO (FWFT)
pages_avail  out  PCNT_W  written, unread pages
busy  out  1  state != IDLE or reads outstanding
wr_wrap  out  1  one-cycle pulse when write pointer wraps
rd_wrap  out  1  one-cycle pulse when read pointer wraps

Behaviour:
- Reset (async assert, sync release): state IDLE; wr_addr, rd_addr, beat_cnt, rd_outstanding and pages_avail = 0; last_grant = READ, so write wins the first tie. All outputs are 0.
- Reset mid-page aborts immediately. No completion of the partial page; pointers return to 0.
- States: IDLE, WR_PAGE, RD_PAGE.
- IDLE. Nothing issues while init_calib_complete=0.
  - wr_ok = cmd_pagewrite & wr_fifo_count ≥ BURST_LEN & pages_avail < NUM_PAGES.
  - rd_ok = cmd_pageread & rd_fifo_space ≥ BURST_LEN & rd_outstanding == 0 & pages_avail > 0.
  - Only one of wr_ok / rd_ok: grant it. Both: grant the opposite of last_grant.
  - On grant: beat_cnt ← 0, update last_grant, go to WR_PAGE or RD_PAGE.
- WR_PAGE:
  - app_en = app_wdf_wren = app_wdf_end = 1, app_cmd = 000, app_addr = wr_addr.
  - A beat is accepted only when app_rdy & app_wdf_rdy are both 1 in the same cycle.
  - wr_fifo_rden = 1 exactly in accept cycles (combinational).
  - On accept: wr_addr += ADDR_STEP; at ring span it wraps to 0 and pulses wr_wrap. beat_cnt++.
  - Accept with beat_cnt == BURST_LEN-1: pages_avail++, go to IDLE.
- RD_PAGE:
  - app_en = 1, app_cmd = 001, app_addr = rd_addr.
  - Accept when app_rdy = 1: rd_addr advances and wraps as on the write side (rd_wrap pulse); rd_outstanding++.
  - Last accept: pages_avail--, go to IDLE.
- rd_outstanding decrements on app_rd_data_valid in any state. Simultaneous accept and return leaves it unchanged. Width is 8 bits; it never exceeds BURST_LEN.
- A page is never preempted. Deassertion of cmd_pagewrite or cmd_pageread mid-page has no effect until the page completes.
- At least one IDLE cycle separates pages.
- All outputs except wr_fifo_rden are decoded from registered state and pointers.
- app_en stays asserted while app_rdy is low; app_addr and app_cmd are held stable.

Decomposition:
- Shared package ddr3_sched_pkg: APP_CMD_WR, APP_CMD_RD, state encoding, and function ring_next(addr) for the wrap rule.
- One sub-module, ddr3_ring_ptr: address register with step and wrap pulse. It is instantiated twice (write pointer, read pointer).

Test Plan:
- Reset, calib=1, cmd_pagewrite=1, wr_fifo_count=64, readys held 1 -> 64 consecutive app_en beats, addresses 0x0..0x1F8, wr_fifo_rden count 64, pages_avail=1.
- Same stimulus with app_wdf_rdy toggling every other cycle -> exactly 64 accepts, no address skip, wr_fifo_rden only in both-ready cycles.
- Both enables high, pages_avail=1, rd_fifo_space=127 -> grants alternate (after first write: read, write, read…). A read is never granted while rd_outstanding>0 or pages_avail=0.
- Write NUM_PAGES=2 pages, then read 2 pages, then write another -> wr_wrap pulse on the 128th write accept, wr_addr=0. A third write is blocked when pages_avail=2.
- Read page with app_rd_data_valid returned concurrently with accepts -> rd_outstanding never exceeds 64 and returns to 0; busy deasserts the cycle after the last return.
- Assert sdram_rst_n=0 at beat 30 of WR_PAGE -> outputs 0 asynchronously; after release, pointers = 0 and pages_avail = 0.

Source files
------------

// File: rtl/ddr3_sched_pkg.sv
// ddr3_sched_pkg: shared MIG command codes, scheduler state encoding and the
// ring-pointer wrap rule used by both page pointers.
package ddr3_sched_pkg;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_PAGE,
        ST_RD_PAGE
    } sched_state_e;

    typedef enum logic {
        GRANT_WR,
        GRANT_RD
    } grant_e;

    function automatic logic [31:0] ring_next(input logic [31:0] addr, input logic [31:0] step,
                                              input logic [31:0] span);
        return (addr + step >= span) ? 32'd0 : addr + step;
    endfunction

endpackage

// File: rtl/ddr3_ring_ptr.sv
// ddr3_ring_ptr: beat address register that steps on each accept and wraps at
// the ring span, with a registered one-cycle wrap pulse.
module ddr3_ring_ptr
    import ddr3_sched_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int ADDR_STEP = 8,
    parameter int SPAN      = 524288
) (
    input  logic              sdramclk,
    input  logic              sdram_rst_n,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q;

    always_comb addr_d = ADDR_W'(ring_next(32'(addr_q), 32'(ADDR_STEP), 32'(SPAN)));

    always_ff @(posedge sdramclk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= adv_i && addr_d == '0;
            if (adv_i) addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/ddr3_page_scheduler.sv
// ddr3_page_scheduler: arbitrates page-sized write and read bursts into MIG app
// commands over a circular DDR3 region, counting stored pages so reads never overtake writes.
module ddr3_page_scheduler
    import ddr3_sched_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int BURST_LEN = 64,
    parameter int ADDR_STEP = 8,
    parameter int NUM_PAGES = 1024,
    parameter int PCNT_W    = 11
) (
    input  logic              sdramclk,
    input  logic              sdram_rst_n,
    input  logic              init_calib_complete,
    input  logic              cmd_pagewrite,
    input  logic              cmd_pageread,
    input  logic [6:0]        wr_fifo_count,
    input  logic [6:0]        rd_fifo_space,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic              wr_fifo_rden,
    output logic [PCNT_W-1:0] pages_avail,
    output logic              busy,
    output logic              wr_wrap,
    output logic              rd_wrap
);

    localparam int SPAN = NUM_PAGES * BURST_LEN * ADDR_STEP;

    sched_state_e      state_q;
    grant_e            last_grant_q;
    logic [6:0]        beat_q;
    logic [7:0]        rd_out_q;
    logic [PCNT_W-1:0] pages_q;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_acc, rd_acc, last_beat, wr_ok, rd_ok, grant_wr;

    always_comb begin
        wr_acc    = state_q == ST_WR_PAGE && app_rdy && app_wdf_rdy;
        rd_acc    = state_q == ST_RD_PAGE && app_rdy;
        last_beat = beat_q == 7'(BURST_LEN - 1);
        wr_ok     = init_calib_complete && cmd_pagewrite && wr_fifo_count >= 7'(BURST_LEN)
                    && pages_q < PCNT_W'(NUM_PAGES);
        rd_ok     = init_calib_complete && cmd_pageread && rd_fifo_space >= 7'(BURST_LEN)
                    && rd_out_q == 8'd0 && pages_q != '0;
        // On a tie the side that did not win last time is served.
        grant_wr  = wr_ok && (!rd_ok || last_grant_q == GRANT_RD);
    end

    always_ff @(posedge sdramclk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RD;
            beat_q       <= '0;
            pages_q      <= '0;
            rd_out_q     <= '0;
        end else begin
            rd_out_q <= rd_out_q + 8'(rd_acc) - 8'(app_rd_data_valid && rd_out_q != 8'd0);
            case (state_q)
                ST_IDLE: if (wr_ok || rd_ok) begin
                    beat_q       <= '0;
                    state_q      <= grant_wr ? ST_WR_PAGE : ST_RD_PAGE;
                    last_grant_q <= grant_wr ? GRANT_WR : GRANT_RD;
                end
                ST_WR_PAGE: if (wr_acc) begin
                    beat_q <= beat_q + 7'd1;
                    if (last_beat) begin
                        pages_q <= pages_q + PCNT_W'(1);
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_PAGE: if (rd_acc) begin
                    beat_q <= beat_q + 7'd1;
                    if (last_beat) begin
                        pages_q <= pages_q - PCNT_W'(1);
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ddr3_ring_ptr #(.ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP), .SPAN(SPAN)) u_wr_ptr (
        .sdramclk   (sdramclk),
        .sdram_rst_n(sdram_rst_n),
        .adv_i      (wr_acc),
        .addr_o     (wr_addr),
        .wrap_o     (wr_wrap)
    );

    ddr3_ring_ptr #(.ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP), .SPAN(SPAN)) u_rd_ptr (
        .sdramclk   (sdramclk),
        .sdram_rst_n(sdram_rst_n),
        .adv_i      (rd_acc),
        .addr_o     (rd_addr),
        .wrap_o     (rd_wrap)
    );

    assign app_en       = state_q != ST_IDLE;
    assign app_cmd      = state_q == ST_RD_PAGE ? APP_CMD_RD : APP_CMD_WR;
    assign app_addr     = state_q == ST_RD_PAGE ? rd_addr : state_q == ST_WR_PAGE ? wr_addr : '0;
    assign app_wdf_wren = state_q == ST_WR_PAGE;
    assign app_wdf_end  = state_q == ST_WR_PAGE;
    assign wr_fifo_rden = wr_acc;
    assign pages_avail  = pages_q;
    assign busy         = state_q != ST_IDLE || rd_out_q != 8'd0;

endmodule
